// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) priority encoder with registered result and valid/ready on both sides.
// Define RR_PRIORITY_ENCODER_ROUND_ROBIN_EN for round-robin search; default is fixed lowest-index priority.
module rr_priority_encoder #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic [7:0]           multi_cnt
);

  localparam int W = $clog2(N);

  logic         accept;
  logic         found;
  logic [W-1:0] win;
  logic [N-1:0] onehot;
  logic         zero;
  logic         multi;
  int           j;

`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan N positions starting at the search base, wrapping explicitly at N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
`else
      j = k;
`endif
      if (!found && in_req[j[W-1:0]]) begin
        found = 1'b1;
        win   = W'(j);
      end
    end
  end

  assign onehot = found ? (N'(1) << win) : '0;
  assign zero   = ~|in_req;
  assign multi  = |(in_req & (in_req - N'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_zero   <= 1'b0;
      out_multi  <= 1'b0;
      multi_cnt  <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_idx    <= win;
      out_onehot <= onehot;
      out_zero   <= zero;
      out_multi  <= multi;
      if (multi && multi_cnt != 8'hff)
        multi_cnt <= multi_cnt + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (accept && found)
      ptr <= (win == W'(N - 1)) ? '0 : win + W'(1);
  end
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder (N=8).
// Expected values follow the build selected by RR_PRIORITY_ENCODER_ROUND_ROBIN_EN.
module tb_rr_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_zero;
  logic       out_multi;
  logic [7:0] multi_cnt;

  rr_priority_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_onehot(out_onehot),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .multi_cnt (multi_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       zero;
    logic       multi;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   m_ptr  = 0;
  int   m_cnt  = 0;
  bit   m_valid = 0;

  task automatic predict(input logic [7:0] req, output exp_t e);
    int w;
    int pc;
    w  = -1;
    pc = $countones(req);
    for (int k = 0; k < 8; k++) begin
      int jj;
`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
      jj = (m_ptr + k) % 8;
`else
      jj = k;
`endif
      if (w < 0 && req[jj]) w = jj;
    end
    e = '0;
    if (w >= 0) begin
      e.idx = w[2:0];
      e.oh  = 8'(1) << w;
      m_ptr = (w + 1) % 8;
    end
    e.zero  = (pc == 0);
    e.multi = (pc >= 2);
    if (pc >= 2 && m_cnt < 255) m_cnt++;
    e.cnt = m_cnt[7:0];
  endtask

  // One clock: drive, predict on accept, advance to just after the edge.
  task automatic drive(input logic v, input logic [7:0] req, input logic ordy);
    bit   acc;
    exp_t e;
    in_valid  = v;
    in_req    = req;
    out_ready = ordy;
    @(negedge clk);
    acc = v && (!m_valid || ordy);
    if (acc) begin
      predict(req, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (acc) m_valid = 1;
    else if (ordy) m_valid = 0;
  endtask

  function automatic exp_t pop();
    if (sbq.size() == 0) return '0;
    return sbq.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_req = '0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00 ||
        out_zero !== 1'b0 || out_multi !== 1'b0 || multi_cnt !== 8'h00)
      $display("FAIL reset_outs: got v=%b i=%0d oh=%h z=%b m=%b c=%0d want all 0",
               out_valid, out_idx, out_onehot, out_zero, out_multi, multi_cnt);
    else passes++;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_onehot_sweep();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(1) << i, 1'b1);
      e = pop();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_idx !== e.idx ||
          out_onehot !== e.oh || out_multi !== 1'b0 || multi_cnt !== 8'd0)
        $display("FAIL sweep[%0d]: got v=%b i=%0d oh=%h m=%b c=%0d want v=1 i=%0d oh=%h m=0 c=0",
                 i, out_valid, out_idx, out_onehot, out_multi, multi_cnt, i, e.oh);
      else passes++;
    end
  endtask

  task automatic test_rr_pattern();
    exp_t       e;
    logic [2:0] want [4];
`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
    want = '{3'd0, 3'd2, 3'd7, 3'd0};
`else
    want = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'b1000_0101, 1'b1);
      e = pop();
      checks++;
      if (out_idx !== want[i] || out_multi !== 1'b1 || multi_cnt !== 8'(i + 1))
        $display("FAIL rr_pattern[%0d]: got i=%0d m=%b c=%0d want i=%0d m=1 c=%0d",
                 i, out_idx, out_multi, multi_cnt, want[i], i + 1);
      else passes++;
      checks++;
      if (out_onehot !== e.oh)
        $display("FAIL rr_onehot[%0d]: got %h want %h", i, out_onehot, e.oh);
      else passes++;
    end
  endtask

  task automatic test_zero();
    exp_t       e;
    logic [2:0] want24;
`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
    want24 = 3'd5;
`else
    want24 = 3'd2;
`endif
    drive(1'b1, 8'h04, 1'b1);
    e = pop();
    checks++;
    if (out_idx !== 3'd2)
      $display("FAIL zero_pre: got %0d want 2", out_idx);
    else passes++;
    drive(1'b1, 8'h00, 1'b1);
    e = pop();
    checks++;
    if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_idx !== 3'd0 ||
        out_onehot !== 8'h00 || out_multi !== 1'b0 || multi_cnt !== e.cnt)
      $display("FAIL zero_vec: got v=%b z=%b i=%0d oh=%h m=%b c=%0d want 1 1 0 00 0 %0d",
               out_valid, out_zero, out_idx, out_onehot, out_multi, multi_cnt, e.cnt);
    else passes++;
    drive(1'b1, 8'h24, 1'b1);
    e = pop();
    checks++;
    if (out_idx !== want24 || out_idx !== e.idx || out_zero !== 1'b0 || out_multi !== 1'b1)
      $display("FAIL zero_ptr_kept: got i=%0d z=%b m=%b want i=%0d z=0 m=1",
               out_idx, out_zero, out_multi, want24);
    else passes++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
    else passes++;
    drive(1'b1, 8'h10, 1'b0);
    e = pop();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_req = 8'hc1 ^ 8'(i * 37);
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0)
        $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready);
      else passes++;
      drive(1'b1, in_req, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_onehot !== 8'h10 ||
          multi_cnt !== e.cnt)
        $display("FAIL bp_frozen[%0d]: got v=%b i=%0d oh=%h c=%0d want 1 4 10 %0d",
                 i, out_valid, out_idx, out_onehot, multi_cnt, e.cnt);
      else passes++;
    end
    in_req = 8'h02;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    else passes++;
    drive(1'b1, 8'h02, 1'b1);
    e = pop();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_onehot !== 8'h02)
      $display("FAIL bp_drain_load: got v=%b i=%0d oh=%h want 1 1 02",
               out_valid, out_idx, out_onehot);
    else passes++;
  endtask

  task automatic test_saturation_reset();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'h03, 1'b1);
      e = pop();
    end
    checks++;
    if (multi_cnt !== 8'd255 || out_multi !== 1'b1)
      $display("FAIL saturate: got c=%0d m=%b want 255 1", multi_cnt, out_multi);
    else passes++;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00 ||
        out_zero !== 1'b0 || out_multi !== 1'b0 || multi_cnt !== 8'h00)
      $display("FAIL async_reset: got v=%b i=%0d oh=%h z=%b m=%b c=%0d want all 0",
               out_valid, out_idx, out_onehot, out_zero, out_multi, multi_cnt);
    else passes++;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL async_reset_ready: got %b want 1", in_ready);
    else passes++;
    m_ptr = 0;
    m_cnt = 0;
    m_valid = 0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 8'b1000_0101, 1'b1);
    e = pop();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_idx !== e.idx || multi_cnt !== 8'd1)
      $display("FAIL post_reset: got v=%b i=%0d c=%0d want 1 0 1",
               out_valid, out_idx, multi_cnt);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_onehot_sweep();
    test_rr_pattern();
    test_zero();
    test_backpressure();
    test_saturation_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised N-to-log2(N) priority encoder with registered output, valid/ready handshakes on both sides and optional round-robin priority rotation. It is the next generation of the team's 8-to-3 one-hot encoder. It accepts arbitrary (multi-hot or zero) request vectors instead of only clean one-hot codes, and it reports multi-hot and zero inputs explicitly. It sits between request sources (interrupt lines, FIFO non-empty flags) and a downstream consumer that can stall.

## Interface
- N, default 8: number of request inputs; legal range 2..256, not required to be a power of two.
- W, derived localparam = $clog2(N): index width (3 for N=8).
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_req holds a vector to encode.
- in_ready  output  1  block can accept a vector this cycle.
- in_req  input  N  request vector; bit i = request i.
- out_valid  output  1  registered result available.
- out_ready  input  1  consumer accepts result this cycle.
- out_idx  output  W  index of the winning request.
- out_onehot  output  N  one-hot mask of the winner; all zero if no request.
- out_zero  output  1  accepted vector had no bits set.
- out_multi  output  1  accepted vector had more than one bit set.
- multi_cnt  output  8  saturating count of accepted multi-hot vectors.

## Operation
- Single output register stage. in_ready = !out_valid || out_ready, which is combinational and gives full throughput.
- Accept event: in_valid && in_ready. On accept, all result fields load together and out_valid goes to 1.
- Result cleared: out_valid && out_ready with no new accept. In that case out_valid goes to 0 and the other result fields hold their values.
- Winner selection (round-robin build): the search starts at pointer ptr (W bits) and scans ptr, ptr+1, … N-1, 0, … ptr-1. The first set bit wins.
- Pointer update: on an accept with nonzero in_req, ptr <= winner+1. If winner = N-1, ptr wraps to 0 (explicit wrap at N, not at 2^W).
- Zero vector accepted: out_idx=0, out_onehot=0, out_zero=1, out_multi=0, ptr unchanged.
- Multi-hot vector (popcount ≥ 2) accepted: out_multi=1 and multi_cnt increments. multi_cnt saturates at 255 and never wraps.
- A one-hot input always yields its own index, regardless of ptr. This matches the legacy 8x3 encoder for every legal one-hot code.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new result loads and out_valid stays 1.

## Timing
- Latency: one clock from accept to out_valid.
- Reset values: out_valid=0, out_idx=0, out_onehot=0, out_zero=0, out_multi=0, multi_cnt=0, ptr=0. in_ready is 1 during and after reset.
- Reset asserted mid-operation discards any held result immediately. No handshake completes in the cycle rst is high.
- Output fields are stable while out_valid && !out_ready. Changes in in_req are ignored while in_ready=0.
- ptr and multi_cnt change only on accept edges.

## Configuration
- Macro: RR_PRIORITY_ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin search from ptr, as described above.
- Undefined: fixed priority, where the lowest set index wins and the ptr register is not built. All other behaviour is identical, including the handshake, the out_zero/out_multi flags and multi_cnt.

## Test plan
- Reset, then feed the one-hot sweep 8'h01…8'h80 with out_ready=1: out_idx = 0…7 on consecutive cycles, out_multi=0, multi_cnt=0.
- Round-robin, in_req=8'b1000_0101 held for 4 accepts: out_idx sequence 0, 2, 7, 0. ptr wraps from 7 to 0. multi_cnt=4.
- Fixed-priority build, same stimulus: out_idx = 0, 0, 0, 0.
- in_req=8'h00 accepted: out_zero=1, out_idx=0, out_onehot=0, ptr unchanged, so the next in_req=8'h24 gives out_idx equal to the round-robin choice from the old ptr.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 and changing in_req: in_ready=0 and the outputs stay frozen at the first result. The first cycle with out_ready=1 drains and loads the next vector in the same cycle.
- Saturation and reset: 300 multi-hot accepts give multi_cnt=255. Asserting rst while out_valid=1 clears all outputs and multi_cnt asynchronously, and the next accept after release starts from ptr=0.
